// File: rtl/precalc_sequencer.sv
// Builds A = H^H*H + snr*I and b = H^H*y with one shared complex multiply-accumulate.
// Define PRECALC_HERMITIAN_SYM_EN to compute only the upper triangle of A and mirror it.
module precalc_sequencer (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:3][0:3][15:0] H_matrix_real,
  input  logic [0:3][0:3][15:0] H_matrix_imag,
  input  logic [0:3][15:0]      signal_receive_real,
  input  logic [0:3][15:0]      signal_receive_imag,
  input  logic [15:0]           snr_real,
  input  logic [15:0]           snr_imag,
  output logic [0:3][0:3][15:0] matrix_A_real,
  output logic [0:3][0:3][15:0] matrix_A_imag,
  output logic [0:3][15:0]      vector_b_real,
  output logic [0:3][15:0]      vector_b_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, DONE} state_t;

  state_t                state_reg;
  logic [0:3][0:3][15:0] h_re_reg, h_im_reg;
  logic [0:3][15:0]      y_re_reg, y_im_reg;
  logic [15:0]           snr_re_reg, snr_im_reg;
  logic [1:0]            i_reg, j_reg, k_reg;
  logic signed [34:0]    acc_re_reg, acc_im_reg;

  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [34:0] base_re, base_im, sum_re, sum_im;
  logic signed [35:0] sh_re, sh_im;
  logic [15:0]        wr_re, wr_im;
  logic               diag;
`ifdef PRECALC_HERMITIAN_SYM_EN
  logic [15:0]        wr_im_neg, diag_im;
`endif

  function automatic logic [15:0] sat16(input logic signed [35:0] v);
    if (v > 36'sd32767)
      return 16'h7fff;
    else if (v < -36'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  // Operand a is always H[k][i]; b is H[k][j] while building A and y[k] while building b.
  always_comb begin
    a_re = h_re_reg[k_reg][i_reg];
    a_im = h_im_reg[k_reg][i_reg];
    if (state_reg == CALC_A) begin
      b_re = h_re_reg[k_reg][j_reg];
      b_im = h_im_reg[k_reg][j_reg];
    end else begin
      b_re = y_re_reg[k_reg];
      b_im = y_im_reg[k_reg];
    end
    p_rr = 32'(a_re) * 32'(b_re);
    p_ii = 32'(a_im) * 32'(b_im);
    p_ri = 32'(a_re) * 32'(b_im);
    p_ir = 32'(a_im) * 32'(b_re);
    diag = (state_reg == CALC_A) && (i_reg == j_reg);
    if (k_reg != 2'd0) begin
      base_re = acc_re_reg;
      base_im = acc_im_reg;
    end else if (diag) begin
      base_re = $signed(35'({snr_re_reg, 13'd0}));
      base_im = $signed(35'({snr_im_reg, 13'd0}));
    end else begin
      base_re = '0;
      base_im = '0;
    end
    // conj(a)*b = (ar*br + ai*bi) + j(ar*bi - ai*br)
    sum_re = base_re + 35'(p_rr) + 35'(p_ii);
    sum_im = base_im + 35'(p_ri) - 35'(p_ir);
    sh_re  = 36'(sum_re) >>> 13;
    sh_im  = 36'(sum_im) >>> 13;
    wr_re  = sat16(sh_re);
    wr_im  = sat16(sh_im);
`ifdef PRECALC_HERMITIAN_SYM_EN
    wr_im_neg = sat16(-sh_im);
    diag_im   = sat16($signed({20'd0, snr_im_reg}));
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      acc_re_reg    <= '0;
      acc_im_reg    <= '0;
      h_re_reg      <= '0;
      h_im_reg      <= '0;
      y_re_reg      <= '0;
      y_im_reg      <= '0;
      snr_re_reg    <= '0;
      snr_im_reg    <= '0;
      matrix_A_real <= '0;
      matrix_A_imag <= '0;
      vector_b_real <= '0;
      vector_b_imag <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            h_re_reg   <= H_matrix_real;
            h_im_reg   <= H_matrix_imag;
            y_re_reg   <= signal_receive_real;
            y_im_reg   <= signal_receive_imag;
            snr_re_reg <= snr_real;
            snr_im_reg <= snr_imag;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= CALC_A;
          end
        end
        CALC_A: begin
          acc_re_reg <= sum_re;
          acc_im_reg <= sum_im;
          k_reg      <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            matrix_A_real[i_reg][j_reg] <= wr_re;
`ifdef PRECALC_HERMITIAN_SYM_EN
            if (diag) begin
              matrix_A_imag[i_reg][j_reg] <= diag_im;
            end else begin
              matrix_A_imag[i_reg][j_reg] <= wr_im;
              matrix_A_real[j_reg][i_reg] <= wr_re;
              matrix_A_imag[j_reg][i_reg] <= wr_im_neg;
            end
`else
            matrix_A_imag[i_reg][j_reg] <= wr_im;
`endif
            if (j_reg == 2'd3) begin
              if (i_reg == 2'd3) begin
                i_reg     <= '0;
                j_reg     <= '0;
                state_reg <= CALC_B;
              end else begin
                i_reg <= i_reg + 2'd1;
`ifdef PRECALC_HERMITIAN_SYM_EN
                j_reg <= i_reg + 2'd1;
`else
                j_reg <= '0;
`endif
              end
            end else begin
              j_reg <= j_reg + 2'd1;
            end
          end
        end
        CALC_B: begin
          acc_re_reg <= sum_re;
          acc_im_reg <= sum_im;
          k_reg      <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            vector_b_real[i_reg] <= wr_re;
            vector_b_imag[i_reg] <= wr_im;
            i_reg <= i_reg + 2'd1;
            if (i_reg == 2'd3)
              state_reg <= DONE;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_precalc_sequencer.sv
// Randomised self-checking bench for precalc_sequencer against a plain-arithmetic reference model.
// Honours PRECALC_HERMITIAN_SYM_EN for the expected latency and mirrored lower triangle.
module tb_precalc_sequencer;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [0:3][0:3][15:0] H_matrix_real, H_matrix_imag;
  logic [0:3][15:0]      signal_receive_real, signal_receive_imag;
  logic [15:0]           snr_real, snr_imag;
  logic [0:3][0:3][15:0] matrix_A_real, matrix_A_imag;
  logic [0:3][15:0]      vector_b_real, vector_b_imag;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

`ifdef PRECALC_HERMITIAN_SYM_EN
  localparam int EXP_LAT = 57;
`else
  localparam int EXP_LAT = 81;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int h_re[4][4], h_im[4][4], y_re[4], y_im[4], snr_re, snr_im;
  int exp_a_re[4][4], exp_a_im[4][4], exp_b_re[4], exp_b_im[4];

  logic [0:3][0:3][15:0] snap_are, snap_aim;
  logic [0:3][15:0]      snap_bre, snap_bim;

  precalc_sequencer dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .H_matrix_real       (H_matrix_real),
    .H_matrix_imag       (H_matrix_imag),
    .signal_receive_real (signal_receive_real),
    .signal_receive_imag (signal_receive_imag),
    .snr_real            (snr_real),
    .snr_imag            (snr_imag),
    .matrix_A_real       (matrix_A_real),
    .matrix_A_imag       (matrix_A_imag),
    .vector_b_real       (vector_b_real),
    .vector_b_imag       (vector_b_imag),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .busy                (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Reference: direct sums over k of conj(H[k][i])*H[k][j] and conj(H[k][i])*y[k].
  task automatic build_model();
    longint sr, si;
    longint sh_im_up[4][4];
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sr = (i == j) ? (longint'(snr_re) << 13) : 0;
        si = (i == j) ? (longint'(snr_im) << 13) : 0;
        for (int k = 0; k < 4; k++) begin
          sr += longint'(h_re[k][i]) * h_re[k][j] + longint'(h_im[k][i]) * h_im[k][j];
          si += longint'(h_re[k][i]) * h_im[k][j] - longint'(h_im[k][i]) * h_re[k][j];
        end
        exp_a_re[i][j] = sat(sr >>> 13);
        exp_a_im[i][j] = sat(si >>> 13);
        sh_im_up[i][j] = si >>> 13;
      end
      sr = 0;
      si = 0;
      for (int k = 0; k < 4; k++) begin
        sr += longint'(h_re[k][i]) * y_re[k] + longint'(h_im[k][i]) * y_im[k];
        si += longint'(h_re[k][i]) * y_im[k] - longint'(h_im[k][i]) * y_re[k];
      end
      exp_b_re[i] = sat(sr >>> 13);
      exp_b_im[i] = sat(si >>> 13);
    end
`ifdef PRECALC_HERMITIAN_SYM_EN
    for (int i = 0; i < 4; i++) begin
      exp_a_im[i][i] = sat(snr_im);
      for (int j = 0; j < i; j++) begin
        exp_a_re[i][j] = exp_a_re[j][i];
        exp_a_im[i][j] = sat(-sh_im_up[j][i]);
      end
    end
`endif
  endtask

  task automatic gen(input int mode);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          0: begin h_re[r][c] = (r == c) ? 32'h2000 : 0; h_im[r][c] = 0; end
          1: begin h_re[r][c] = 0; h_im[r][c] = 0; end
          2: begin h_re[r][c] = 32'h7fff; h_im[r][c] = 0; end
          3: begin h_re[r][c] = 32'h0400 * (r + c); h_im[r][c] = 32'h0200 * (r - c); end
          4: begin h_re[r][c] = rnd16(); h_im[r][c] = rnd16(); end
          default: begin
            h_re[r][c] = int'($urandom_range(0, 4095)) - 2048;
            h_im[r][c] = int'($urandom_range(0, 4095)) - 2048;
          end
        endcase
      end
      case (mode)
        0: begin
          y_re[r] = (r == 0) ? 32'h2000 : (r == 1) ? 32'h4000 : (r == 2) ? -32'h2000 : 32'h1000;
          y_im[r] = 0;
        end
        1, 2: begin y_re[r] = 0; y_im[r] = 0; end
        4: begin y_re[r] = rnd16(); y_im[r] = rnd16(); end
        default: begin
          y_re[r] = int'($urandom_range(0, 8191)) - 4096;
          y_im[r] = int'($urandom_range(0, 8191)) - 4096;
        end
      endcase
    end
    case (mode)
      0, 2: begin snr_re = 0; snr_im = 0; end
      1: begin snr_re = 32'h0800; snr_im = 32'h0100; end
      3: begin snr_re = 32'h0100; snr_im = 0; end
      4: begin snr_re = int'($urandom_range(0, 65535)); snr_im = int'($urandom_range(0, 65535)); end
      default: begin snr_re = int'($urandom_range(0, 2047)); snr_im = int'($urandom_range(0, 2047)); end
    endcase
  endtask

  task automatic drive_ports();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        H_matrix_real[r][c] = 16'(h_re[r][c]);
        H_matrix_imag[r][c] = 16'(h_im[r][c]);
      end
      signal_receive_real[r] = 16'(y_re[r]);
      signal_receive_imag[r] = 16'(y_im[r]);
    end
    snr_real = 16'(snr_re);
    snr_imag = 16'(snr_im);
  endtask

  // Operands presented after acceptance must be ignored.
  task automatic scramble_ports();
    H_matrix_real       = {8{$urandom}};
    H_matrix_imag       = {8{$urandom}};
    signal_receive_real = {2{$urandom}};
    signal_receive_imag = {2{$urandom}};
    snr_real            = 16'($urandom);
    snr_imag            = 16'($urandom);
  endtask

  task automatic compare_outputs(input string tag);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("%s A_re[%0d][%0d]", tag, i, j), int'($signed(matrix_A_real[i][j])), exp_a_re[i][j]);
        check_eq($sformatf("%s A_im[%0d][%0d]", tag, i, j), int'($signed(matrix_A_imag[i][j])), exp_a_im[i][j]);
      end
      check_eq($sformatf("%s b_re[%0d]", tag, i), int'($signed(vector_b_real[i])), exp_b_re[i]);
      check_eq($sformatf("%s b_im[%0d]", tag, i), int'($signed(vector_b_imag[i])), exp_b_im[i]);
    end
  endtask

  task automatic take_snapshot();
    snap_are = matrix_A_real;
    snap_aim = matrix_A_imag;
    snap_bre = vector_b_real;
    snap_bim = vector_b_imag;
  endtask

  function automatic int outputs_match_snapshot();
    return int'(matrix_A_real == snap_are && matrix_A_imag == snap_aim &&
                vector_b_real == snap_bre && vector_b_imag == snap_bim);
  endfunction

  function automatic int outputs_all_zero();
    return int'(matrix_A_real == '0 && matrix_A_imag == '0 &&
                vector_b_real == '0 && vector_b_imag == '0);
  endfunction

  task automatic run_txn(input string name, input int mode, input int hold);
    int lat;
    gen(mode);
    build_model();
    @(negedge clock);
    check_eq({name, " in_ready_idle"}, int'(in_ready), 1);
    drive_ports();
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    scramble_ports();
    check_eq({name, " in_ready_after_accept"}, int'(in_ready), 0);
    check_eq({name, " busy_after_accept"}, int'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_eq({name, " latency"}, lat, EXP_LAT);
    compare_outputs(name);
    take_snapshot();
    for (int c = 0; c < hold; c++) begin
      @(posedge clock);
      #1;
      check_eq({name, " hold_stable"}, outputs_match_snapshot(), 1);
      check_eq({name, " hold_in_ready"}, int'(in_ready), 0);
      check_eq({name, " hold_busy"}, int'(busy), 1);
      check_eq({name, " hold_out_valid"}, int'(out_valid), 1);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq({name, " post_hs_in_ready"}, int'(in_ready), 1);
    check_eq({name, " post_hs_out_valid"}, int'(out_valid), 0);
    check_eq({name, " post_hs_busy"}, int'(busy), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    check_eq({name, " idle_retain"}, outputs_match_snapshot(), 1);
    $display("txn %s: mode %0d latency %0d hold %0d", name, mode, lat, hold);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    H_matrix_real = '0;
    H_matrix_imag = '0;
    signal_receive_real = '0;
    signal_receive_imag = '0;
    snr_real = '0;
    snr_imag = '0;
    #12;
    check_eq("reset in_ready", int'(in_ready), 0);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset out_valid", int'(out_valid), 0);
    check_eq("reset outputs_zero", outputs_all_zero(), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("release in_ready", int'(in_ready), 1);
    check_eq("release busy", int'(busy), 0);
    $display("txn reset_release: in_ready %0d", in_ready);

    run_txn("identity", 0, 0);
    run_txn("snr_preload", 1, 0);
    run_txn("saturation", 2, 0);
    run_txn("hermitian", 3, 0);
    run_txn("backpressure", 5, 10);
    for (int t = 0; t < 6; t++)
      run_txn($sformatf("random%0d", t), (t % 2 == 0) ? 4 : 5, t % 3);

    // Abort mid-operation with reset.
    gen(5);
    @(negedge clock);
    drive_ports();
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("abort out_valid", int'(out_valid), 0);
    check_eq("abort busy", int'(busy), 0);
    check_eq("abort in_ready", int'(in_ready), 0);
    check_eq("abort outputs_zero", outputs_all_zero(), 1);
    repeat (3) @(posedge clock);
    #1;
    check_eq("abort held out_valid", int'(out_valid), 0);
    check_eq("abort held in_ready", int'(in_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("abort release in_ready", int'(in_ready), 1);
    check_eq("abort release out_valid", int'(out_valid), 0);
    $display("txn reset_abort: in_ready %0d busy %0d", in_ready, busy);

    run_txn("post_reset", 4, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
